// File: rtl/pipe_stage_buf.sv
// Purpose : flow-controlled pipeline stage register with a 2-entry skid buffer and synchronous flush.
// Latency : 1 cycle from accept to output when the stage is empty, or holds one entry that drains in the same cycle.
// Backpressure: in_ready comes only from registered state. At most one extra entry is taken into the skid slot after out_ready drops.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   flush              squashes every held entry into a bubble
//   in_valid/in_ready  upstream handshake; in_data/in_ctrl carry the payload
//   out_valid/out_ready downstream handshake; out_data/out_ctrl carry the head entry
//   occupancy          number of held entries (0..2)
module pipe_stage_buf #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // The encoding is {skid_valid, main_valid}, so each valid bit is read directly from the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main_dat;
    logic [CTRL_W-1:0] r_main_ctl;
    logic [DATA_W-1:0] r_skid_dat;
    logic [CTRL_W-1:0] r_skid_ctl;

    logic w_main_vld;
    logic w_skid_vld;
    logic w_in_fire;
    logic w_out_fire;
    logic w_ld_main_in;    // main <= upstream payload
    logic w_ld_skid_in;    // skid <= upstream payload
    logic w_ld_main_skid;  // main <= skid (promotion on drain from FULL)

    assign w_main_vld = r_state[0];
    assign w_skid_vld = r_state[1];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_main_vld & out_ready;

    assign in_ready  = ~w_skid_vld;
    assign out_valid = w_main_vld;
    assign out_data  = r_main_dat;
    // A bubble must never carry live control bits downstream.
    assign out_ctrl  = w_main_vld ? r_main_ctl : '0;
    assign occupancy = {1'b0, w_main_vld} + {1'b0, w_skid_vld};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_skid_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        if (flush) begin
            // Flush discards any same-cycle input. A same-cycle output transfer
            // has already been seen downstream, so nothing needs to be undone.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_ld_skid_in = 1'b1;
                        w_state_nxt  = ST_FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;  // unreachable encoding 2'b10
            endcase
        end
    end

    // Payload registers load only when their entry is written. Flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_dat <= '0;
            r_main_ctl <= '0;
            r_skid_dat <= '0;
            r_skid_ctl <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_dat <= in_data;
                r_main_ctl <= in_ctrl;
            end else if (w_ld_main_skid) begin
                r_main_dat <= r_skid_dat;
                r_main_ctl <= r_skid_ctl;
            end
            if (w_ld_skid_in) begin
                r_skid_dat <= in_data;
                r_skid_ctl <= in_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_ctrl = '0;
    logic        out_ready = 1'b0;

    logic        in_ready16, out_valid16, in_ready32, out_valid32;
    logic [15:0] out_data16;
    logic [4:0]  out_ctrl16;
    logic [31:0] out_data32;
    logic [2:0]  out_ctrl32;
    logic [1:0]  occ16, occ32;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(16), .CTRL_W(5)) u_dut16 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data[15:0]), .in_ctrl(in_ctrl),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_ctrl(out_ctrl16),
        .occupancy(occ16)
    );

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(3)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_data(in_data), .in_ctrl(in_ctrl[2:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_data(out_data32), .out_ctrl(out_ctrl32),
        .occupancy(occ32)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  c;
    } ent_t;

    ent_t exp_q[$];        // scoreboard: accepted entries in expected output order
    int   occ = 0;         // reference model: entries held by the stage
    bit   armed = 0;       // checks start once a reset has taken effect
    bit   after_rst = 0;   // first cycle after reset: storage must read zero
    bit   p_rst = 0, p_flush = 0, p_in = 0, p_out = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One cycle of stimulus. The model first applies what happened at the edge
    // just passed, then predicts the transfers for the inputs driven now.
    task automatic step(input bit r, input bit f, input bit iv,
                        input logic [31:0] d, input logic [4:0] c, input bit ordy);
        ent_t e;
        @(posedge clk);
        #1;
        after_rst = p_rst;
        if (p_rst || p_flush) begin
            occ = 0;
            exp_q.delete();
            if (p_rst) armed = 1;
        end else begin
            occ = occ + int'(p_in) - int'(p_out);
        end
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        p_in    = iv && (occ < 2);
        p_out   = (occ > 0) && ordy;
        p_rst   = r;
        p_flush = f;
        if (p_in && !r && !f) begin
            e.d = d;
            e.c = c;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 5'h0, ordy);
    endtask

    // Monitor: checks handshake and status every cycle, and pops the
    // scoreboard whenever the stage hands an entry downstream.
    always @(negedge clk) begin
        ent_t e;
        if (armed) begin
            chk("in_ready16",  {31'b0, in_ready16},  {31'b0, occ < 2});
            chk("in_ready32",  {31'b0, in_ready32},  {31'b0, occ < 2});
            chk("out_valid16", {31'b0, out_valid16}, {31'b0, occ > 0});
            chk("out_valid32", {31'b0, out_valid32}, {31'b0, occ > 0});
            chk("occupancy16", {30'b0, occ16}, occ);
            chk("occupancy32", {30'b0, occ32}, occ);
            if (!out_valid16) chk("bubble_ctrl16", {27'b0, out_ctrl16}, 32'h0);
            if (!out_valid32) chk("bubble_ctrl32", {29'b0, out_ctrl32}, 32'h0);
            if (after_rst) begin
                chk("rst_data16", {16'b0, out_data16}, 32'h0);
                chk("rst_data32", out_data32, 32'h0);
            end
            if (out_valid16 && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data16", {16'b0, out_data16}, {16'b0, e.d[15:0]});
                    chk("ctrl16", {27'b0, out_ctrl16}, {27'b0, e.c});
                    chk("data32", out_data32, e.d);
                    chk("ctrl32", {29'b0, out_ctrl32}, {29'b0, e.c[2:0]});
                end
            end
        end
    end

    initial begin
        // Reset for two cycles while upstream offers a payload.
        step(1, 0, 1, 32'hDEAD_BEEF, 5'h1F, 1'b0);
        step(1, 0, 1, 32'hDEAD_BEEF, 5'h1F, 1'b0);
        idle(2, 1'b0);

        // Streaming with out_ready held high.
        step(0, 0, 1, 32'h1, 5'h01, 1'b1);
        step(0, 0, 1, 32'h2, 5'h01, 1'b1);
        step(0, 0, 1, 32'h3, 5'h01, 1'b1);
        step(0, 0, 1, 32'hDEAD_BEEF, 5'h06, 1'b1);
        idle(2, 1'b1);

        // Skid and back-pressure: C must wait until the skid slot frees.
        step(0, 0, 1, 32'h0A00, 5'h0A, 1'b1);
        step(0, 0, 1, 32'h0B00, 5'h0B, 1'b0);
        step(0, 0, 1, 32'h0C00, 5'h0C, 1'b0);
        step(0, 0, 1, 32'h0C00, 5'h0C, 1'b0);
        step(0, 0, 1, 32'h0C00, 5'h0C, 1'b1);
        step(0, 0, 1, 32'h0C00, 5'h0C, 1'b1);
        idle(2, 1'b1);

        // Flush while full, then a fresh entry right after.
        step(0, 0, 1, 32'h0A01, 5'h11, 1'b0);
        step(0, 0, 1, 32'h0B01, 5'h12, 1'b0);
        step(0, 1, 0, 32'h0, 5'h0, 1'b0);
        step(0, 0, 1, 32'h0D00, 5'h0D, 1'b0);
        idle(2, 1'b1);

        // Flush with a simultaneous input: E is discarded.
        step(0, 0, 1, 32'h0A02, 5'h13, 1'b0);
        step(0, 1, 1, 32'h0E00, 5'h0E, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom,
                 5'($urandom),
                 $urandom_range(0, 9) < 6);
        end
        idle(4, 1'b1);
        chk("drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
